// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: byte FIFO on a valid/ready write port feeding a
// START/DATA/STOP serialiser. Define UART_TX_PARITY_EN to add an even-parity bit.
module uart_tx_fifo #(
  parameter int ClockFrequency = 125_000_000,
  parameter int BaudRate       = 15_625_000,
  parameter int FifoDepth      = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic [7:0]                     wdata_i,
  input  logic                           wvalid_i,
  output logic                           wready_o,
  output logic                           tx_o,
  output logic                           busy_o,
  output logic [$clog2(FifoDepth+1)-1:0] level_o
);

  localparam int CPB    = ClockFrequency / BaudRate;
  localparam int PtrW   = $clog2(FifoDepth);
  localparam int LevelW = $clog2(FifoDepth + 1);
  localparam int CntW   = (CPB > 2) ? $clog2(CPB) : 1;
  localparam logic [LevelW-1:0] FULL_LEVEL = LevelW'(FifoDepth);
  localparam logic [CntW-1:0]   BAUD_LAST  = CntW'(CPB - 1);

  generate
    if ((ClockFrequency % BaudRate) != 0 || CPB < 2 ||
        FifoDepth < 2 || (FifoDepth & (FifoDepth - 1)) != 0) begin : g_bad_cfg
      $error("uart_tx_fifo: CPB must be an integer >= 2 and FifoDepth a power of two >= 2");
    end
  endgenerate

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

  logic [7:0]        mem [FifoDepth];
  logic [PtrW-1:0]   wr_ptr_reg, rd_ptr_reg;
  logic [LevelW-1:0] count_reg;
  state_t            state_reg, state_next;
  logic [CntW-1:0]   baud_reg, baud_next;
  logic [2:0]        bit_reg, bit_next;
  logic [7:0]        shift_reg, shift_next;
  logic              tx_reg, tx_next;
  logic              push, pop, fifo_empty, baud_done;

  assign fifo_empty = (count_reg == '0);
  assign wready_o   = (count_reg != FULL_LEVEL);
  assign push       = wvalid_i && wready_o;
  assign baud_done  = (baud_reg == BAUD_LAST);
  assign level_o    = count_reg;
  assign tx_o       = tx_reg;
  assign busy_o     = (state_reg != IDLE) || !fifo_empty;

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= wdata_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PtrW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PtrW'(1);
      // Occupancy is the single source of truth for full/empty.
      case ({push, pop})
        2'b10:   count_reg <= count_reg + LevelW'(1);
        2'b01:   count_reg <= count_reg - LevelW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      tx_reg    <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      tx_reg    <= tx_next;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity_reg;

  always_ff @(posedge clk_i) begin
    if (!rst_ni)  parity_reg <= 1'b0;
    else if (pop) parity_reg <= ^mem[rd_ptr_reg];
  end
`endif

  // Line level is registered from the current state, so it trails the FSM by one cycle.
  always_comb begin
    state_next = state_reg;
    baud_next  = baud_done ? '0 : baud_reg + CntW'(1);
    bit_next   = bit_reg;
    shift_next = shift_reg;
    tx_next    = 1'b1;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop        = 1'b1;
          shift_next = mem[rd_ptr_reg];
          state_next = START;
        end
      end
      START: begin
        tx_next = 1'b0;
        if (baud_done) begin
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        tx_next = shift_reg[0];
        if (baud_done) begin
          shift_next = {1'b0, shift_reg[7:1]};
          bit_next   = bit_reg + 3'd1;
          if (bit_reg == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        tx_next = parity_reg;
        if (baud_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (baud_done) begin
          // Chain straight into the next start bit when more data is waiting.
          if (!fifo_empty) begin
            pop        = 1'b1;
            shift_next = mem[rd_ptr_reg];
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed self-checking bench for uart_tx_fifo at CPB=8, depth 16, with a
// line decoder sampling tx_o mid-bit on the falling clock edge.
module tb_uart_tx_fifo;

  localparam int CPB   = 8;
  localparam int DEPTH = 16;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk_i    = 1'b0;
  logic       rst_ni   = 1'b0;
  logic [7:0] wdata_i  = 8'h00;
  logic       wvalid_i = 1'b0;
  logic       wready_o, tx_o, busy_o;
  logic [4:0] level_o;

  uart_tx_fifo #(
    .ClockFrequency(125_000_000),
    .BaudRate      (15_625_000),
    .FifoDepth     (DEPTH)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .wdata_i (wdata_i),
    .wvalid_i(wvalid_i),
    .wready_o(wready_o),
    .tx_o    (tx_o),
    .busy_o  (busy_o),
    .level_o (level_o)
  );

  always #4 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Receiver model: start-bit detect, then sample each slot at its midpoint.
  logic [7:0] rx_q[$];
  int         rx_t[$];
  logic       rx_par[$];
  int         rx_bad = 0;
  int         cyc = 0;
  bit         rx_active = 1'b0;
  int         rx_phase = 0;
  int         rx_t0 = 0;
  int         rx_slot = 0;
  logic [7:0] rx_sh = 8'h00;
  logic       rx_p = 1'b0;

  always @(negedge clk_i) begin
    cyc++;
    if (!rst_ni) begin
      rx_active = 1'b0;
    end else if (!rx_active) begin
      if (tx_o == 1'b0) begin
        rx_active = 1'b1;
        rx_phase  = 0;
        rx_t0     = cyc;
      end
    end else begin
      rx_phase++;
      if (rx_phase % CPB == CPB / 2) begin
        rx_slot = rx_phase / CPB;
        if (rx_slot >= 1 && rx_slot <= 8) begin
          rx_sh[rx_slot-1] = tx_o;
        end else if (NBITS == 11 && rx_slot == 9) begin
          rx_p = tx_o;
        end else if (rx_slot == NBITS - 1) begin
          if (tx_o !== 1'b1) rx_bad++;
          rx_q.push_back(rx_sh);
          rx_t.push_back(rx_t0);
          rx_par.push_back(rx_p);
          rx_active = 1'b0;
        end
      end
    end
  end

  task automatic clear_rx();
    rx_q.delete();
    rx_t.delete();
    rx_par.delete();
  endtask

  task automatic wait_rx(input int n, input int budget, input string tag);
    int k = 0;
    while (rx_q.size() < n && k < budget) begin
      step();
      k++;
    end
    check(tag, rx_q.size(), n);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    while (busy_o !== 1'b0 && k < budget) begin
      step();
      k++;
    end
    check(tag, busy_o, 1'b0);
    repeat (4) step();
  endtask

  task automatic push_byte(input logic [7:0] b);
    wdata_i  = b;
    wvalid_i = 1'b1;
    step();
    wvalid_i = 1'b0;
  endtask

  initial begin
    logic [7:0] slot_bits;
    logic [7:0] b55;
    logic       exp_bit, busy_pre;
    int         idx, k, max_level, lows;
    bit         acc, saw_full, saw_refill, chk_next;
    logic [4:0] prev_level;

    // Reset state
    rst_ni = 1'b0;
    repeat (3) step();
    check("rst_tx", tx_o, 1'b1);
    check("rst_wready", wready_o, 1'b1);
    check("rst_busy", busy_o, 1'b0);
    check("rst_level", level_o, 5'd0);
    rst_ni = 1'b1;
    step();

    // Single frame 0x55, cycle-exact from the push edge
    b55 = 8'h55;
    clear_rx();
    push_byte(b55);
    check("t1_level_push", level_o, 5'd1);
    step();
    check("t1_tx_before_start", tx_o, 1'b1);
    check("t1_level_popped", level_o, 5'd0);
    check("t1_busy", busy_o, 1'b1);
    busy_pre = 1'b0;
    for (int s = 0; s < NBITS; s++) begin
      if (s == 0)              exp_bit = 1'b0;
      else if (s <= 8)         exp_bit = b55[s-1];
      else if (s == NBITS - 1) exp_bit = 1'b1;
      else                     exp_bit = ^b55;
      for (int b = 0; b < 8; b++) begin
        step();
        slot_bits[b] = tx_o;
        if (s == NBITS - 1 && b == 6) busy_pre = busy_o;
      end
      check($sformatf("t1_slot%0d", s), slot_bits, {8{exp_bit}});
    end
    check("t1_busy_last_cycle", busy_pre, 1'b1);
    check("t1_busy_done", busy_o, 1'b0);
    check("t1_level_done", level_o, 5'd0);
    wait_rx(1, 20, "t1_rx_count");
    if (rx_q.size() >= 1) check("t1_rx_byte", rx_q[0], 8'h55);

    // Back-to-back frames with no idle gap
    wait_idle(50, "t2_idle");
    clear_rx();
    push_byte(8'hA5);
    push_byte(8'h3C);
    wait_rx(2, 400, "t2_rx_count");
    if (rx_q.size() >= 2) begin
      check("t2_byte0", rx_q[0], 8'hA5);
      check("t2_byte1", rx_q[1], 8'h3C);
      check("t2_frame_spacing", rx_t[1] - rx_t[0], NBITS * CPB);
    end

    // Continuous writer: fill to full, push blocked during a pop, refill after
    wait_idle(400, "t4_idle");
    clear_rx();
    idx = 0; k = 0; max_level = 0;
    saw_full = 1'b0; saw_refill = 1'b0; chk_next = 1'b0;
    prev_level = level_o;
    while (idx < 20 && k < 3000) begin
      wdata_i  = 8'h30 + 8'(idx);
      wvalid_i = 1'b1;
      acc = wready_o;
      step();
      k++;
      if (acc) idx++;
      if (int'(level_o) > max_level) max_level = int'(level_o);
      if (chk_next) begin
        check("t5_refill_level", level_o, 5'd16);
        chk_next = 1'b0;
      end
      if (level_o == 5'd16 && !saw_full) begin
        saw_full = 1'b1;
        check("t4_wready_full", wready_o, 1'b0);
      end
      if (prev_level == 5'd16 && level_o == 5'd15 && !saw_refill) begin
        saw_refill = 1'b1;
        chk_next   = 1'b1;
        check("t5_wready_after_pop", wready_o, 1'b1);
      end
      prev_level = level_o;
    end
    wvalid_i = 1'b0;
    check("t4_accepted", idx, 20);
    check("t4_max_level", max_level, DEPTH);
    check("t5_saw_full_pop", saw_refill, 1'b1);
    wait_rx(20, 20 * NBITS * CPB + 400, "t4_rx_count");
    for (int i = 0; i < 20 && i < rx_q.size(); i++)
      check($sformatf("t4_byte%0d", i), rx_q[i], 8'h30 + 8'(i));

    // Reset in the third data bit with bytes queued; writer active during reset
    wait_idle(400, "t6_idle");
    clear_rx();
    push_byte(8'hC1);
    push_byte(8'hC2);
    push_byte(8'hC3);
    push_byte(8'hC4);
    k = 0;
    while (!(rx_active && rx_phase >= 3 * CPB + 2) && k < 200) begin
      step();
      k++;
    end
    check("t6_reached_bit2", rx_active, 1'b1);
    wdata_i  = 8'hEE;
    wvalid_i = 1'b1;
    rst_ni   = 1'b0;
    step();
    rst_ni   = 1'b1;
    wvalid_i = 1'b0;
    check("t6_tx_after_rst", tx_o, 1'b1);
    check("t6_level_after_rst", level_o, 5'd0);
    check("t6_busy_after_rst", busy_o, 1'b0);
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      step();
      if (tx_o !== 1'b1) lows++;
    end
    check("t6_line_quiet", lows, 0);
    check("t6_rx_none", rx_q.size(), 0);

`ifdef UART_TX_PARITY_EN
    // Even parity over the data bits
    clear_rx();
    push_byte(8'h07);
    push_byte(8'h03);
    wait_rx(2, 400, "t7_rx_count");
    if (rx_q.size() >= 2) begin
      check("t7_byte07", rx_q[0], 8'h07);
      check("t7_par07", rx_par[0], 1'b1);
      check("t7_byte03", rx_q[1], 8'h03);
      check("t7_par03", rx_par[1], 1'b0);
      check("t7_frame_len", rx_t[1] - rx_t[0], 88);
    end
`endif

    check("stop_bits_ok", rx_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- Buffered UART transmitter inside system_multicore; drives the system's serial transmit line (uart_tx_o) toward the simulation UART model or board pin.
- Accepts bytes from the management-core peripheral interface over a valid/ready handshake.
- Buffers bytes in a FIFO and serialises each one as 8N1, LSB first, at BaudRate.

Parameters:
- ClockFrequency, 125_000_000: system clock in Hz.
- BaudRate, 15_625_000: line rate in bit/s.
- FifoDepth, 16: byte entries; power of two, >= 2.
- Derived constant CPB = ClockFrequency/BaudRate, here 8.
  - Elaboration error unless CPB is an integer >= 2.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  synchronous active-low reset.
- wdata_i  input  8  byte to transmit.
- wvalid_i  input  1  wdata_i valid.
- wready_o  output  1  FIFO can accept.
- tx_o  output  1  serial line, idle high.
- busy_o  output  1  FIFO non-empty or frame in progress.
- level_o  output  $clog2(FifoDepth+1)  current FIFO occupancy.

Behaviour:
- Interface: one clock (clk_i); reset rst_ni is synchronous and active-low, sampled on the rising edge of clk_i.
- Reset values:
  - tx_o=1, wready_o=1, busy_o=0, level_o=0.
  - FSM=IDLE, FIFO pointers and bit/baud counters cleared.
- Handshake:
  - Byte accepted on a rising edge where wvalid_i && wready_o.
  - wready_o = (level_o != FifoDepth), purely from registered state.
  - A push while full is ignored, even if a pop happens the same cycle; the writer holds wdata_i.
- Level update:
  - Push and pop in the same cycle leaves level_o unchanged.
  - level_o reflects the edge's updates in the following cycle.
- FSM states: IDLE, START, DATA, STOP; baud counter 0..CPB-1; bit index 0..7.
  - IDLE: tx_o=1. If FIFO non-empty: pop the head into the shift register and go to START.
  - START: tx_o=0 for CPB cycles, then go to DATA with bit index 0.
  - DATA: tx_o=shift[0] for CPB cycles per bit; shift right after each bit. After bit 7, go to STOP.
  - STOP: tx_o=1 for CPB cycles. Then:
    - FIFO non-empty: pop and go directly to START, with no idle gap between frames.
    - FIFO empty: go to IDLE.
- Latency:
  - Byte pushed into an empty FIFO while IDLE at edge N: tx_o first low after edge N+2, i.e. one cycle in IDLE to pop.
  - Frame length 10*CPB cycles (80 at defaults).
- Wrap-around:
  - Read and write pointers are $clog2(FifoDepth) bits and wrap naturally.
  - Full/empty are derived from a separate occupancy counter.
- busy_o = (state != IDLE) || (level_o != 0).
- Reset mid-frame: at the reset edge, tx_o returns to 1, FIFO contents are discarded, and the FSM goes to IDLE. No partial-frame completion.
- wvalid_i while in reset: ignored.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - Extra PARITY state between DATA and STOP.
  - tx_o = XOR of the 8 data bits (even parity) for CPB cycles.
  - Frame is 11*CPB cycles.
- Undefined:
  - No PARITY state; 10*CPB cycles per frame (8N1).
  - No parity logic synthesised.

Test Plan:
- Reset then push 0x55 at edge N (CPB=8) -> tx_o low from N+2 for 8 cycles, then bits 1,0,1,0,1,0,1,0 at 8 cycles each, stop high for 8 cycles. busy_o drops after 80 cycles of frame; level_o returns to 0.
- Push 0xA5 and 0x3C back-to-back -> two frames totalling 160 contiguous cycles, with the second start bit immediately after the first stop bit. Decoded bytes are 0xA5 then 0x3C.
- Hold wvalid_i high with 20 distinct bytes while the line is running:
  - wready_o deasserts when level_o reaches 16.
  - Next byte is accepted one cycle after a pop.
  - All 20 bytes appear in order, none lost or duplicated.
- Assert rst_ni=0 for one cycle at the 3rd data bit of a frame with 4 bytes queued -> tx_o=1 and level_o=0 the next cycle; no further frames emitted.
- With FIFO full, assert wvalid_i in the same cycle as a pop -> push not accepted; level_o goes 16->15; push accepted the next cycle.
- UART_TX_PARITY_EN defined:
  - Send 0x07 -> parity bit 1, frame 88 cycles.
  - Send 0x03 -> parity bit 0.
